// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types and width helpers for the cache/bus round-robin arbiter.
// Packet layout is {write, addr[31:0], data[dma_data_width*32-1:0]}.
package cache_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_RESP = 2'd2
    } cb_arb_state_e;

    localparam int cb_addr_width_lp = 32;

    function automatic int cache_bus_pkt_width(input int dma_data_width);
        return 1 + cb_addr_width_lp + dma_data_width * 32;
    endfunction

    // Index width that never collapses to zero bits for a single requester.
    function automatic int cb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Cache-side and bus-side handshake bundle of the arbiter.
// The master modport is the arbiter itself, which masters the shared bus.
interface cache_bus_arbiter_if
    import cache_bus_arbiter_pkg::*;
#(
    parameter int num_caches_p     = 4,
    parameter int dma_data_width_p = 8
);
    localparam int pkt_w_lp = cache_bus_pkt_width(dma_data_width_p);

    logic [num_caches_p-1:0]          c_valid_i;
    logic [num_caches_p*pkt_w_lp-1:0] c_pkt_i;
    logic [num_caches_p-1:0]          c_yumi_o;
    logic [num_caches_p-1:0]          c_valid_o;
    logic [dma_data_width_p*32-1:0]   c_data_o;
    logic                             b_valid_o;
    logic [pkt_w_lp-1:0]              b_pkt_o;
    logic                             b_yumi_i;
    logic                             b_valid_i;
    logic [dma_data_width_p*32-1:0]   b_data_i;

    modport master (
        input  c_valid_i, c_pkt_i, b_yumi_i, b_valid_i, b_data_i,
        output c_yumi_o, c_valid_o, c_data_o, b_valid_o, b_pkt_o
    );

    modport slave (
        output c_valid_i, c_pkt_i, b_yumi_i, b_valid_i, b_data_i,
        input  c_yumi_o, c_valid_o, c_data_o, b_valid_o, b_pkt_o
    );

endinterface

// File: rtl/cache_bus_arbiter_rr_arbiter.sv
// Combinational rotating-priority select: first set request at or above ptr,
// wrapping at width_p.
module rr_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int width_p = 4
) (
    input  logic [width_p-1:0]               req,
    input  logic [cb_idx_width(width_p)-1:0] ptr,
    output logic [width_p-1:0]               grant_oh,
    output logic [cb_idx_width(width_p)-1:0] grant_idx,
    output logic                             any_v
);
    localparam int idx_w_lp = cb_idx_width(width_p);

    always_comb begin
        int j;
        j         = 0;
        grant_oh  = '0;
        grant_idx = '0;
        any_v     = 1'b0;
        for (int i = 0; i < width_p; i++) begin
            j = int'(ptr) + i;
            if (j >= width_p) j = j - width_p;
            if (!any_v && req[j]) begin
                any_v       = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = idx_w_lp'(j);
            end
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter between num_caches_p caches and one shared bus; one
// outstanding transaction, response pulse routed back to the requester.
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int num_caches_p     = 4,
    parameter int dma_data_width_p = 8
) (
    input  logic                                  clk_i,
    input  logic                                  nreset_i,
    cache_bus_arbiter_if.master                   bus,
    output logic [cb_idx_width(num_caches_p)-1:0] grant_o,
    output logic                                  err_o
);
    localparam int pkt_w_lp = cache_bus_pkt_width(dma_data_width_p);
    localparam int idx_w_lp = cb_idx_width(num_caches_p);

    cb_arb_state_e state_r, state_n;

    logic [idx_w_lp-1:0]     grant_r;
    logic [num_caches_p-1:0] grant_oh_r;
    logic [idx_w_lp-1:0]     rr_ptr_r;
    logic                    err_r;

    logic [num_caches_p-1:0] arb_oh;
    logic [idx_w_lp-1:0]     arb_idx;
    logic                    arb_v;

    logic accept, complete, spurious;

    rr_arbiter #(.width_p(num_caches_p)) u_rr (
        .req      (bus.c_valid_i),
        .ptr      (rr_ptr_r),
        .grant_oh (arb_oh),
        .grant_idx(arb_idx),
        .any_v    (arb_v)
    );

    // A completion in GRANT happens when the bus accepts and responds in one cycle.
    assign accept   = (state_r == GRANT) && bus.b_yumi_i;
    assign complete = bus.b_valid_i && ((state_r == WAIT_RESP) || accept);
    assign spurious = bus.b_valid_i &&
                      ((state_r == IDLE) || ((state_r == GRANT) && !bus.b_yumi_i));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) state_r <= IDLE;
        else           state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE:      if (arb_v)            state_n = GRANT;
            GRANT:     if (accept)           state_n = bus.b_valid_i ? IDLE : WAIT_RESP;
            WAIT_RESP: if (bus.b_valid_i)    state_n = IDLE;
            default:                         state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.b_valid_o = 1'b0;
        bus.b_pkt_o   = '0;
        bus.c_yumi_o  = '0;
        bus.c_valid_o = '0;
        if (state_r == GRANT) begin
            bus.b_valid_o = 1'b1;
            bus.b_pkt_o   = bus.c_pkt_i[int'(grant_r)*pkt_w_lp +: pkt_w_lp];
            if (bus.b_yumi_i) bus.c_yumi_o = grant_oh_r;
        end
        if (complete) bus.c_valid_o = grant_oh_r;
    end

    assign bus.c_data_o = bus.b_data_i;

    // Grant capture, pointer advance after completion, sticky protocol error.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            grant_r    <= '0;
            grant_oh_r <= '0;
            rr_ptr_r   <= '0;
            err_r      <= 1'b0;
        end else begin
            if (state_r == IDLE && arb_v) begin
                grant_r    <= arb_idx;
                grant_oh_r <= arb_oh;
            end
            if (complete) begin
                if (int'(grant_r) == num_caches_p - 1) rr_ptr_r <= '0;
                else                                   rr_ptr_r <= grant_r + 1'b1;
            end
            if (spurious) err_r <= 1'b1;
        end
    end

    assign grant_o = grant_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter with four caches and a hand-driven bus.
module tb_cache_bus_arbiter;
    import cache_bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int PW = cache_bus_pkt_width(DW);

    logic         clk_i = 1'b0;
    logic         nreset_i;
    logic [1:0]   grant_o;
    logic         err_o;
    logic [PW-1:0] pkts [N];

    int n_vec  = 0;
    int n_miss = 0;

    cache_bus_arbiter_if #(.num_caches_p(N), .dma_data_width_p(DW)) bus ();

    cache_bus_arbiter #(.num_caches_p(N), .dma_data_width_p(DW)) dut (
        .clk_i   (clk_i),
        .nreset_i(nreset_i),
        .bus     (bus),
        .grant_o (grant_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one transaction for cache idx, starting from IDLE with its request driven.
    task automatic serve(input int idx, input bit same_cycle, input bit drop_req);
        logic [3:0]   oh;
        logic [255:0] d;
        oh = 4'(1 << idx);
        d  = {8{32'hD00D0000 + 32'(idx)}};
        tick();
        #1;
        chk("grant_idx", grant_o, idx);
        chk("b_valid_grant", bus.b_valid_o, 1);
        chk("b_pkt", bus.b_pkt_o, pkts[idx]);
        chk("yumi_before_accept", bus.c_yumi_o, 0);
        bus.b_yumi_i = 1'b1;
        bus.b_data_i = d;
        if (same_cycle) bus.b_valid_i = 1'b1;
        #1;
        chk("c_yumi", bus.c_yumi_o, oh);
        if (same_cycle) begin
            chk("c_valid_same_cycle", bus.c_valid_o, oh);
            chk("c_data_same_cycle", bus.c_data_o, d);
        end else begin
            chk("c_valid_early", bus.c_valid_o, 0);
        end
        tick();
        bus.b_yumi_i  = 1'b0;
        bus.b_valid_i = 1'b0;
        if (drop_req) bus.c_valid_i[idx] = 1'b0;
        if (!same_cycle) begin
            #1;
            chk("b_valid_wait", bus.b_valid_o, 0);
            chk("c_yumi_wait", bus.c_yumi_o, 0);
            chk("c_valid_wait", bus.c_valid_o, 0);
            bus.b_valid_i = 1'b1;
            #1;
            chk("c_valid_resp", bus.c_valid_o, oh);
            chk("c_data_resp", bus.c_data_o, d);
            tick();
            bus.b_valid_i = 1'b0;
        end
        #1;
        chk("idle_b_valid", bus.b_valid_o, 0);
        chk("idle_c_valid", bus.c_valid_o, 0);
    endtask

    initial begin
        for (int k = 0; k < N; k++)
            pkts[k] = {1'b0, 32'h40 | (32'(k) << 12), {8{32'hA5A50000 + 32'(k)}}};
        bus.c_pkt_i   = {pkts[3], pkts[2], pkts[1], pkts[0]};
        bus.c_valid_i = '0;
        bus.b_yumi_i  = 1'b0;
        bus.b_valid_i = 1'b0;
        bus.b_data_i  = '0;
        nreset_i      = 1'b0;
        tick();
        tick();
        chk("rst_b_valid", bus.b_valid_o, 0);
        chk("rst_c_yumi", bus.c_yumi_o, 0);
        chk("rst_c_valid", bus.c_valid_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_err", err_o, 0);
        nreset_i = 1'b1;
        tick();

        // Single request from cache 2; bus request appears one cycle later.
        bus.c_valid_i = 4'b0100;
        #1;
        chk("t1_no_comb_b_valid", bus.b_valid_o, 0);
        serve(2, 1'b0, 1'b1);

        // Pointer now 3: of caches 0 and 3, cache 3 wins.
        bus.c_valid_i = 4'b1001;
        serve(3, 1'b0, 1'b1);

        // All four requesting from pointer 0: 0,1,2,3,0.
        bus.c_valid_i = 4'b1111;
        serve(0, 1'b0, 1'b0);
        serve(1, 1'b0, 1'b0);
        serve(2, 1'b0, 1'b0);
        serve(3, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b0);

        // Pointer 1 -> serve cache 1 alone, leaving pointer at 2.
        bus.c_valid_i = 4'b0010;
        serve(1, 1'b0, 1'b1);

        // Caches 1 and 3 with pointer 2: 3 first, then 1.
        bus.c_valid_i = 4'b1010;
        serve(3, 1'b0, 1'b1);
        serve(1, 1'b0, 1'b1);

        // Accept and response in the same cycle.
        bus.c_valid_i = 4'b0001;
        serve(0, 1'b1, 1'b1);

        // Spurious response in IDLE.
        bus.b_valid_i = 1'b1;
        #1;
        chk("spur_idle_c_valid", bus.c_valid_o, 0);
        tick();
        bus.b_valid_i = 1'b0;
        #1;
        chk("spur_idle_err", err_o, 1);
        chk("spur_idle_stays", bus.b_valid_o, 0);
        bus.c_valid_i = 4'b0100;
        serve(2, 1'b0, 1'b1);
        chk("err_sticky", err_o, 1);

        // Reset in WAIT_RESP abandons the transaction.
        bus.c_valid_i = 4'b1000;
        tick();
        bus.b_yumi_i = 1'b1;
        tick();
        bus.b_yumi_i  = 1'b0;
        bus.c_valid_i = 4'b0000;
        #1;
        nreset_i      = 1'b0;
        bus.b_valid_i = 1'b1;
        #1;
        chk("mid_rst_c_valid", bus.c_valid_o, 0);
        chk("mid_rst_b_valid", bus.b_valid_o, 0);
        chk("mid_rst_c_yumi", bus.c_yumi_o, 0);
        chk("mid_rst_grant", grant_o, 0);
        chk("mid_rst_err", err_o, 0);
        tick();
        bus.b_valid_i = 1'b0;
        nreset_i      = 1'b1;

        // After reset arbitration restarts at cache 0; response without accept is an error.
        bus.c_valid_i = 4'b1111;
        tick();
        #1;
        chk("post_rst_grant", grant_o, 0);
        bus.b_valid_i = 1'b1;
        #1;
        chk("spur_grant_c_valid", bus.c_valid_o, 0);
        chk("spur_grant_c_yumi", bus.c_yumi_o, 0);
        tick();
        bus.b_valid_i = 1'b0;
        #1;
        chk("spur_grant_err", err_o, 1);
        chk("spur_grant_stays", bus.b_valid_o, 1);
        chk("spur_grant_idx", grant_o, 0);
        bus.b_yumi_i  = 1'b1;
        bus.b_valid_i = 1'b1;
        #1;
        chk("post_rst_c_valid", bus.c_valid_o, 4'b0001);
        tick();
        bus.b_yumi_i  = 1'b0;
        bus.b_valid_i = 1'b0;
        bus.c_valid_i = 4'b0000;
        #1;
        chk("post_rst_idle", bus.b_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
